// File: rtl/bidirectional_piso_serializer.sv
// rtl/bidirectional_piso_serializer.sv - parallel-in serial-out shifter with per-word MSB/LSB-first order
module bidirectional_piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             mode,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             mode_q;
  logic [CW-1:0]    count;
  logic             last_bit;

  // The final bit of a frame is the only SHIFT cycle where a new word may be taken.
  assign last_bit   = (state == SHIFT) && (count == LAST);

  // All outputs derive from registers only, so they are glitch-free relative to inputs.
  assign dout       = (state == SHIFT) ? (mode_q ? shreg[WIDTH-1] : shreg[0]) : 1'b0;
  assign dout_valid = (state == SHIFT);
  assign busy       = (state == SHIFT);
  assign done       = last_bit;
  assign load_ready = (state == IDLE) || last_bit;

  // Frame sequencer: load on handshake, shift toward the output end, reload back-to-back on the last bit.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state  <= IDLE;
      shreg  <= '0;
      mode_q <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            shreg  <= din;
            mode_q <= mode;
            count  <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit && load_valid) begin
            shreg  <= din;
            mode_q <= mode;
            count  <= '0;
          end else begin
            shreg <= mode_q ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
            if (last_bit) begin
              count <= '0;
              state <= IDLE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bidirectional_piso_serializer.sv
// tb/tb_bidirectional_piso_serializer.sv - directed and random bench against a bit-queue reference model
module tb_bidirectional_piso_serializer;

  localparam int W = 8;

  logic         clock;
  logic         rst;
  logic [W-1:0] din;
  logic         mode;
  logic         load_valid;
  logic         load_ready;
  logic         dout;
  logic         dout_valid;
  logic         busy;
  logic         done;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference: pending serial bits in transmit order, each tagged with whether it ends a frame.
  bit bq[$];
  bit lq[$];

  bidirectional_piso_serializer #(.WIDTH(W)) dut (
    .clock      (clock),
    .rst        (rst),
    .din        (din),
    .mode       (mode),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0b expected=%0b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare just after the edge.
  task automatic step(input logic r, input logic lv, input logic [W-1:0] d, input logic m);
    bit ready_before;
    rst        = r;
    load_valid = lv;
    din        = d;
    mode       = m;
    @(posedge clock);
    if (!r) begin
      bq.delete();
      lq.delete();
    end else begin
      ready_before = (bq.size() == 0) || lq[0];
      if (bq.size() > 0) begin
        void'(bq.pop_front());
        void'(lq.pop_front());
      end
      if (lv && ready_before) begin
        for (int i = 0; i < W; i++) begin
          bq.push_back(m ? d[W-1-i] : d[i]);
          lq.push_back(i == W - 1);
        end
      end
    end
    #1;
    chk("dout_valid", dout_valid, bq.size() > 0);
    chk("busy",       busy,       bq.size() > 0);
    chk("dout",       dout,       (bq.size() > 0) ? bq[0] : 1'b0);
    chk("done",       done,       (bq.size() > 0) && lq[0]);
    chk("load_ready", load_ready, (bq.size() == 0) || lq[0]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, W'($urandom), 1'($urandom));
  endtask

  initial begin
    rst        = 1'b0;
    load_valid = 1'b0;
    din        = '0;
    mode       = 1'b0;

    // Reset held for two edges, with load_valid asserted to show it is ignored.
    step(1'b0, 1'b1, 8'hAA, 1'b1);
    step(1'b0, 1'b1, 8'h55, 1'b0);
    idle(2);

    // MSB-first frame, then return to idle.
    step(1'b1, 1'b1, 8'hB2, 1'b1);
    idle(9);

    // LSB-first frame.
    step(1'b1, 1'b1, 8'hB2, 1'b0);
    idle(9);

    // Back-to-back frames: next word offered only in the last-bit cycle.
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    idle(7);
    step(1'b1, 1'b1, 8'h00, 1'b1);
    idle(9);

    // Mid-frame load attempt with a different mode must be ignored.
    step(1'b1, 1'b1, 8'hA5, 1'b1);
    idle(2);
    step(1'b1, 1'b1, 8'h3C, 1'b0);
    idle(6);

    // Reset after three bits aborts the frame; a fresh word then serializes cleanly.
    step(1'b1, 1'b1, 8'hC3, 1'b1);
    idle(2);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h81, 1'b0);
    idle(9);

    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 4), W'($urandom), 1'($urandom));
    end
    idle(10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
